traffic_sink: RTL and testbench

Destination endpoint for NoC traffic: it accepts flits ejected from a router's local port and checks packet framing and destination per virtual channel. It counts received packets and flits, returns one credit per accepted flit, and asserts `done` once a programmed number of packets has fully arrived. It is the receiving counterpart of the traffic generator and is programmed through the same `op`/`data` style command bus by the testbench or top-level controller.

---
 rtl/traffic_sink.sv | 157 +++++++++++++++
 tb/tb_traffic_sink.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sink.sv
// traffic_sink: NoC ejection endpoint. Checks per-VC packet framing and the
// head-flit destination, counts packets and flits, returns one credit per
// presented flit, and raises done once the programmed packet count completes.
module traffic_sink #(
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned VC_BITS   = 2,
  parameter int unsigned DEST_BITS = 14,
  parameter int unsigned MY_ADDR   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           op,
  input  logic [9:0]           data,
  input  logic                 flit_valid,
  input  logic                 flit_head,
  input  logic                 flit_tail,
  input  logic [VC_BITS-1:0]   flit_vc,
  input  logic [DEST_BITS-1:0] flit_dst,
  output logic                 credit_valid,
  output logic [VC_BITS-1:0]   credit_vc,
  output logic [9:0]           pkt_count,
  output logic [15:0]          flit_count,
  output logic                 done,
  output logic                 err_frame,
  output logic                 err_dest,
  output logic                 err_unexp
);

  localparam logic [DEST_BITS-1:0] MyAddr = DEST_BITS'(MY_ADDR);

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_INIT  = 2'd1,
    OP_CLERR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [9:0]           expected_q, expected_d;
  logic [NUM_VC-1:0]    in_pkt_q, in_pkt_d;
  logic [9:0]           pkt_cnt_q, pkt_cnt_d;
  logic [15:0]          flit_cnt_q, flit_cnt_d;
  logic                 err_frame_q, err_frame_d;
  logic                 err_dest_q, err_dest_d;
  logic                 err_unexp_q, err_unexp_d;
  logic                 credit_valid_q, credit_valid_d;
  logic [VC_BITS-1:0]   credit_vc_q, credit_vc_d;
  logic                 done_q, done_d;
  logic                 vc_open;

  // Next-state computation: command handling, flit acceptance and credit return
  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    in_pkt_d       = in_pkt_q;
    pkt_cnt_d      = pkt_cnt_q;
    flit_cnt_d     = flit_cnt_q;
    err_frame_d    = err_frame_q;
    err_dest_d     = err_dest_q;
    err_unexp_d    = err_unexp_q;
    credit_valid_d = flit_valid;
    credit_vc_d    = flit_valid ? flit_vc : credit_vc_q;
    vc_open        = in_pkt_q[flit_vc];

    // Clear first so an error event later in this block overrides it
    if (op_e'(op) == OP_CLERR) begin
      err_frame_d = 1'b0;
      err_dest_d  = 1'b0;
      err_unexp_d = 1'b0;
    end

    if (op_e'(op) == OP_INIT) begin
      // Init takes priority; a simultaneous flit only earns its credit
      expected_d  = data;
      in_pkt_d    = '0;
      pkt_cnt_d   = '0;
      flit_cnt_d  = '0;
      err_frame_d = 1'b0;
      err_dest_d  = 1'b0;
      err_unexp_d = 1'b0;
      state_d     = (data == '0) ? DONE : RUN;
    end else if (flit_valid) begin
      if (state_q != RUN) begin
        err_unexp_d = 1'b1;
      end else begin
        if (flit_cnt_q != '1) begin
          flit_cnt_d = flit_cnt_q + 16'd1;
        end
        if (flit_head) begin
          if (vc_open) begin
            err_frame_d = 1'b1;
          end
          if (flit_dst != MyAddr) begin
            err_dest_d = 1'b1;
          end
        end else if (!vc_open) begin
          err_frame_d = 1'b1;
        end
        in_pkt_d[flit_vc] = flit_tail ? 1'b0 : (flit_head | vc_open);
        // A tail only completes a packet that was opened by a head
        if (flit_tail && (flit_head || vc_open)) begin
          pkt_cnt_d = pkt_cnt_q + 10'd1;
          if (pkt_cnt_d == expected_q) begin
            state_d = DONE;
          end
        end
      end
    end

    done_d = (state_d == DONE);
  end

  // State and registered outputs with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      expected_q     <= '0;
      in_pkt_q       <= '0;
      pkt_cnt_q      <= '0;
      flit_cnt_q     <= '0;
      err_frame_q    <= 1'b0;
      err_dest_q     <= 1'b0;
      err_unexp_q    <= 1'b0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      in_pkt_q       <= in_pkt_d;
      pkt_cnt_q      <= pkt_cnt_d;
      flit_cnt_q     <= flit_cnt_d;
      err_frame_q    <= err_frame_d;
      err_dest_q     <= err_dest_d;
      err_unexp_q    <= err_unexp_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      done_q         <= done_d;
    end
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;
  assign pkt_count    = pkt_cnt_q;
  assign flit_count   = flit_cnt_q;
  assign done         = done_q;
  assign err_frame    = err_frame_q;
  assign err_dest     = err_dest_q;
  assign err_unexp    = err_unexp_q;

endmodule

// File: tb/tb_traffic_sink.sv
// Bench for traffic_sink: directed packet scenarios, a packet-level reference
// model checked against every output each cycle, plus literal spot checks.
module tb_traffic_sink;

  localparam int ADDR = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  op;
  logic [9:0]  data;
  logic        flit_valid, flit_head, flit_tail;
  logic [1:0]  flit_vc;
  logic [13:0] flit_dst;
  logic        credit_valid;
  logic [1:0]  credit_vc;
  logic [9:0]  pkt_count;
  logic [15:0] flit_count;
  logic        done, err_frame, err_dest, err_unexp;

  traffic_sink #(.NUM_VC(4), .VC_BITS(2), .DEST_BITS(14), .MY_ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .op(op), .data(data),
    .flit_valid(flit_valid), .flit_head(flit_head), .flit_tail(flit_tail),
    .flit_vc(flit_vc), .flit_dst(flit_dst),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .pkt_count(pkt_count), .flit_count(flit_count), .done(done),
    .err_frame(err_frame), .err_dest(err_dest), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: packet-level view of what the sink should report
  bit m_run, m_done, m_ef, m_ed, m_eu, m_cv;
  int m_cvc, m_pkts, m_flits, m_exp;
  bit m_open [4];

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_ef = 0; m_ed = 0; m_eu = 0; m_cv = 0;
      m_cvc = 0; m_pkts = 0; m_flits = 0; m_exp = 0;
      for (int v = 0; v < 4; v++) m_open[v] = 0;
    end else begin
      m_cv = flit_valid;
      if (flit_valid) m_cvc = int'(flit_vc);
      if (op == 2) begin m_ef = 0; m_ed = 0; m_eu = 0; end
      if (op == 1) begin
        m_ef = 0; m_ed = 0; m_eu = 0; m_pkts = 0; m_flits = 0;
        for (int v = 0; v < 4; v++) m_open[v] = 0;
        m_exp = int'(data);
        m_done = (data == 0);
        m_run = !m_done;
      end else if (flit_valid) begin
        if (!m_run) m_eu = 1;
        else begin
          bit started;
          started = flit_head || m_open[flit_vc];
          if (m_flits < 65535) m_flits++;
          if (flit_head && m_open[flit_vc]) m_ef = 1;
          if (!flit_head && !m_open[flit_vc]) m_ef = 1;
          if (flit_head && int'(flit_dst) != ADDR) m_ed = 1;
          m_open[flit_vc] = started && !flit_tail;
          if (flit_tail && started) begin
            m_pkts++;
            if (m_pkts == m_exp) begin m_run = 0; m_done = 1; end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, plus credit tallies per VC
  int crd [4];
  initial for (int v = 0; v < 4; v++) crd[v] = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("credit_valid", int'(credit_valid), int'(m_cv));
    if (m_cv) cmp("credit_vc", int'(credit_vc), m_cvc);
    cmp("pkt_count", int'(pkt_count), m_pkts);
    cmp("flit_count", int'(flit_count), m_flits);
    cmp("done", int'(done), int'(m_done));
    cmp("err_frame", int'(err_frame), int'(m_ef));
    cmp("err_dest", int'(err_dest), int'(m_ed));
    cmp("err_unexp", int'(err_unexp), int'(m_eu));
    if (credit_valid) crd[credit_vc]++;
  end

  task automatic lit(input string name, input int act, input int exp);
    cmp(name, act, exp);
  endtask

  // Stimulus helpers: inputs change right after a falling edge
  task automatic send(input int vc, input bit h, input bit t, input int dst);
    flit_valid = 1; flit_head = h; flit_tail = t;
    flit_vc = 2'(vc); flit_dst = 14'(dst);
    @(negedge clk);
    flit_valid = 0; flit_head = 0; flit_tail = 0;
  endtask

  task automatic cmd(input int o, input int d);
    op = 2'(o); data = 10'(d);
    @(negedge clk);
    op = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    idle(2);
    reset = 0;
  endtask

  int c0;

  initial begin
    reset = 1; op = 0; data = 0; flit_valid = 0; flit_head = 0; flit_tail = 0;
    flit_vc = 0; flit_dst = 0;
    @(negedge clk);
    do_reset();
    lit("rst_pkt", int'(pkt_count), 0);
    lit("rst_flit", int'(flit_count), 0);
    lit("rst_done", int'(done), 0);
    lit("rst_credit", int'(credit_valid), 0);
    lit("rst_credit_vc", int'(credit_vc), 0);

    // Normal run: 3 packets on VC1 of 1, 2 and 4 flits
    cmd(1, 3);
    c0 = crd[1];
    send(1, 1, 1, ADDR);
    send(1, 1, 0, ADDR); send(1, 0, 1, ADDR);
    send(1, 1, 0, ADDR); send(1, 0, 0, ADDR); send(1, 0, 0, ADDR);
    lit("norm_done_before", int'(done), 0);
    send(1, 0, 1, ADDR);
    lit("norm_pkt", int'(pkt_count), 3);
    lit("norm_flit", int'(flit_count), 7);
    lit("norm_done", int'(done), 1);
    idle(1);
    lit("norm_credits", crd[1] - c0, 7);
    lit("norm_errs", int'({err_frame, err_dest, err_unexp}), 0);
    // Tail in DONE is unexpected and not counted
    send(1, 0, 1, ADDR);
    lit("done_tail_unexp", int'(err_unexp), 1);
    lit("done_tail_pkt", int'(pkt_count), 3);
    lit("done_tail_flit", int'(flit_count), 7);

    // Interleaved VCs
    cmd(1, 2);
    send(0, 1, 0, ADDR);
    send(2, 1, 0, ADDR);
    send(0, 0, 0, ADDR);
    lit("ilv_pkt0", int'(pkt_count), 0);
    send(2, 0, 1, ADDR);
    lit("ilv_pkt1", int'(pkt_count), 1);
    lit("ilv_done1", int'(done), 0);
    send(0, 0, 1, ADDR);
    lit("ilv_pkt2", int'(pkt_count), 2);
    lit("ilv_done2", int'(done), 1);
    lit("ilv_frame", int'(err_frame), 0);

    // Framing errors on VC3
    cmd(1, 5);
    send(3, 0, 0, ADDR);
    lit("frm_err1", int'(err_frame), 1);
    send(3, 1, 0, ADDR);
    send(3, 1, 0, ADDR);
    lit("frm_flit", int'(flit_count), 3);
    lit("frm_pkt", int'(pkt_count), 0);
    cmd(2, 0);
    lit("frm_clr", int'(err_frame), 0);
    // ClearErr colliding with a new framing error: error wins
    op = 2; send(3, 1, 0, ADDR); op = 0;
    lit("clr_collide", int'(err_frame), 1);

    // Destination mismatch
    cmd(1, 1);
    c0 = crd[0];
    send(0, 1, 1, ADDR + 1);
    lit("dst_err", int'(err_dest), 1);
    lit("dst_pkt", int'(pkt_count), 1);
    lit("dst_done", int'(done), 1);
    idle(1);
    lit("dst_credit", crd[0] - c0, 1);

    // Unexpected traffic in IDLE, then Init colliding with a flit
    do_reset();
    send(0, 1, 1, ADDR);
    lit("idle_unexp", int'(err_unexp), 1);
    lit("idle_flit", int'(flit_count), 0);
    lit("idle_credit", int'(credit_valid), 1);
    op = 1; data = 2; send(2, 1, 0, ADDR); op = 0;
    lit("coll_flit", int'(flit_count), 0);
    lit("coll_unexp", int'(err_unexp), 0);
    lit("coll_credit", int'(credit_valid), 1);
    lit("coll_credit_vc", int'(credit_vc), 2);
    // VC2 head was discarded, so this body flit is a framing error
    send(2, 0, 0, ADDR);
    lit("coll_frame", int'(err_frame), 1);

    // Reset mid-packet
    cmd(1, 2);
    send(0, 1, 0, ADDR);
    reset = 1; send(0, 0, 0, ADDR); reset = 0;
    lit("mid_rst_credit", int'(credit_valid), 0);
    lit("mid_rst_flit", int'(flit_count), 0);
    lit("mid_rst_frame", int'(err_frame), 0);
    send(1, 1, 1, ADDR);
    lit("mid_rst_idle", int'(err_unexp), 1);
    cmd(1, 1);
    send(0, 1, 1, ADDR);
    lit("mid_rst_pkt", int'(pkt_count), 1);
    lit("mid_rst_done", int'(done), 1);
    lit("mid_rst_noframe", int'(err_frame), 0);

    // Init with zero expected packets
    cmd(1, 0);
    lit("zero_done", int'(done), 1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
